// File: rtl/tcb_lib_arbiter_if.sv
// TCB bus interface: valid/ready request handshake in byte-enable mode,
// fixed-delay response (DLY cycles after the request transfer).
interface tcb_if #(
  parameter int unsigned DLY = 1,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
);
  logic          vld;
  logic          rdy;
  logic          cmd;
  logic          wen;
  logic          ndn;
  logic [AW-1:0] adr;
  logic [1:0]    siz;
  logic [DW/8-1:0] ben;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          sts;

  modport man (output vld, cmd, wen, ndn, adr, siz, ben, wdt, input  rdy, rdt, sts);
  modport sub (input  vld, cmd, wen, ndn, adr, siz, ben, wdt, output rdy, rdt, sts);
endinterface

// File: rtl/tcb_lib_arbiter.sv
// Round-robin arbiter sharing one TCB subordinate between IFN managers;
// responses are steered back through a DLY-deep {valid, index} delay line.
module tcb_lib_arbiter #(
  parameter int unsigned IFN = 2,
  parameter int unsigned IFL = $clog2(IFN),
  parameter int unsigned DLY = 1
)(
  input  logic clk,
  input  logic rst,
  tcb_if.sub   sub [0:IFN-1],
  tcb_if.man   man
);

  localparam int unsigned AW = man.AW;
  localparam int unsigned DW = man.DW;
  localparam int unsigned BW = DW / 8;

  // An interface array shares one parameter set, so sub[0] stands for all.
  if (IFN < 2 || IFN > 16) begin : g_err_ifn
    $fatal(1, "tcb_lib_arbiter: IFN out of range 2..16");
  end
  if (man.DLY != DLY || sub[0].DLY != DLY) begin : g_err_dly
    $fatal(1, "tcb_lib_arbiter: DLY mismatch between arbiter and ports");
  end
  if (sub[0].AW != AW || sub[0].DW != DW) begin : g_err_phy
    $fatal(1, "tcb_lib_arbiter: PHY mismatch between sub and man");
  end

  logic [IFN-1:0] vld_a;
  logic           cmd_a [IFN];
  logic           wen_a [IFN];
  logic           ndn_a [IFN];
  logic [AW-1:0]  adr_a [IFN];
  logic [1:0]     siz_a [IFN];
  logic [BW-1:0]  ben_a [IFN];
  logic [DW-1:0]  wdt_a [IFN];

  logic [IFL-1:0] ptr;
  logic [IFL-1:0] gnt;
  logic [IFL-1:0] lgn;
  logic [IFL-1:0] cand;
  logic           lck;
  logic           found;
  logic           man_vld;
  logic           trn;
  logic           rsp_vld;
  logic [IFL-1:0] rsp_idx;

  for (genvar i = 0; i < IFN; i++) begin : g_sub
    assign vld_a[i] = sub[i].vld;
    assign cmd_a[i] = sub[i].cmd;
    assign wen_a[i] = sub[i].wen;
    assign ndn_a[i] = sub[i].ndn;
    assign adr_a[i] = sub[i].adr;
    assign siz_a[i] = sub[i].siz;
    assign ben_a[i] = sub[i].ben;
    assign wdt_a[i] = sub[i].wdt;

    assign sub[i].rdy = man.rdy && (gnt == IFL'(i));
    assign sub[i].rdt = (rsp_vld && (rsp_idx == IFL'(i))) ? man.rdt : '0;
    assign sub[i].sts = (rsp_vld && (rsp_idx == IFL'(i))) ? man.sts : '0;
  end

  always_comb begin
    gnt   = ptr;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < IFN; k++) begin
      cand = IFL'((32'(ptr) + k) % IFN);
      if (!found && vld_a[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
    // A stalled request keeps its grant until it completes.
    if (lck) begin
      gnt = lgn;
    end
  end

  assign man_vld = |vld_a;
  assign trn     = man_vld && man.rdy;

  assign man.vld = man_vld;
  assign man.cmd = cmd_a[gnt];
  assign man.wen = wen_a[gnt];
  assign man.ndn = ndn_a[gnt];
  assign man.adr = adr_a[gnt];
  assign man.siz = siz_a[gnt];
  assign man.ben = ben_a[gnt];
  assign man.wdt = wdt_a[gnt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      lck <= 1'b0;
      lgn <= '0;
    end else if (trn) begin
      lck <= 1'b0;
      ptr <= (gnt == IFL'(IFN - 1)) ? '0 : gnt + IFL'(1);
    end else if (man_vld) begin
      lck <= 1'b1;
      lgn <= gnt;
    end
  end

  if (DLY == 0) begin : g_nodly
    assign rsp_vld = trn;
    assign rsp_idx = gnt;
  end else begin : g_dly
    localparam int unsigned LW = DLY * IFL;
    logic [DLY-1:0] dv;
    logic [LW-1:0]  di;

    // Shifts every cycle: responses are fixed-delay and never stall.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dv <= '0;
        di <= '0;
      end else begin
        dv <= DLY'({dv, trn});
        di <= LW'({di, gnt});
      end
    end

    assign rsp_vld = dv[DLY-1];
    assign rsp_idx = di[LW-1 -: IFL];
  end

endmodule

// File: doc/tcb_lib_arbiter.md
# tcb_lib_arbiter

Round-robin arbiter that shares one TCB subordinate device between `IFN` TCB manager devices. Requests pass combinationally from the granted subordinate port to the single manager port. Responses return to the originating port after the fixed bus response delay `DLY`, routed by an internal select delay line. It sits between CPU/DMA-style managers and a shared memory or peripheral. All ports use byte-enable mode with identical PHY parameters.

## Interface
- `IFN`, default 2: number of subordinate ports (managers sharing the bus); range 2..16.
- `IFL`, default `$clog2(IFN)`: grant index width; derived, do not override.
- `DLY`, default 1: response delay in cycles between a request transfer and its response; must equal `man.DLY` and every `sub[i].DLY`; range 0..4.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `sub[IFN]`, `tcb_if.sub`, interface array: subordinate ports; managers connect here.
- `man`, `tcb_if.man`, interface: manager port; the shared subordinate device connects here.

## Operation
- **Transfer:** a transfer on any port occurs when `vld && rdy` at a rising edge of `clk`.
- **Arbitration:** combinational grant `gnt` is the first port with `sub[i].vld=1`, searching from pointer `ptr` upward, modulo `IFN`.
- **Lock:**
  - Register `lck` is set when `man.vld=1` and `man.rdy=0`.
  - `lck` is cleared on the cycle the transfer completes.
  - While `lck=1`, `gnt` holds the registered index `lgn`, regardless of other requests. A stalled request is never preempted.
- **Pointer:** on every `man` transfer, `ptr <= gnt+1` (wraps to 0 after `IFN-1`). Without a transfer, `ptr` holds.
- **Request path:**
  - `man.vld = |sub[*].vld`.
  - `man.req = sub[gnt].req` (`cmd`, `wen`, `ndn`, `adr`, `siz`, `ben`, `wdt`).
  - `sub[i].rdy = man.rdy && (gnt==i)`.
  - Non-granted ports see `rdy=0`.
- **Response routing:**
  - Delay line of `DLY` stages, each holding {valid, index}.
  - Stage 0 loads {transfer, `gnt`} every cycle; stage k loads stage k-1.
  - The output stage selects `sub[idx].rsp = man.rsp` (`rdt`, `sts`) when valid.
  - All other ports get `rsp.rdt='0`, `rsp.sts='0`.
  - With `DLY=0`, routing uses the current `gnt` combinationally and there is no delay line.
- **No idle transfers:** if no `sub[i].vld` is asserted, `man.vld=0` and `man.req` follows port `ptr` (don't care).
- **Parameter check:** an elaboration-time check issues `$fatal` on mismatched `DLY` or PHY parameters between `sub[*]` and `man`.

## Timing
- **Reset values:** `ptr=0`, `lck=0`, `lgn=0`, all delay-line valid bits 0.
- **Outputs during reset:**
  - `man.vld` follows its inputs combinationally.
  - Every `sub[i].rsp` reads 0, because no valid stage exists.
- **Request latency:** 0 cycles; `sub` to `man` is purely combinational.
- **Response latency:** exactly `DLY` cycles after the transfer, unchanged by the arbiter.
- **Back-to-back transfers:** one transfer per cycle is sustained. Under full load, ports alternate strictly: 0,1,...,IFN-1,0.
- **Simultaneous requests:** the port nearest at/above `ptr` wins. Example: `ptr=1`, `IFN=4`, vld on 0 and 3 -> port 3.
- **New request during lock:** a port asserting `vld` while another port is locked waits. It is considered only after the locked transfer completes.
- **Reset mid-operation:**
  - In-flight responses are discarded; valid bits clear, so no `rsp` is routed.
  - `lck` clears and `ptr` returns to 0 immediately (asynchronous).
- **Wrap-around:** a transfer granted to port `IFN-1` sets `ptr=0`.
- **Delay-line validity:** the delay line shifts every cycle regardless of `man.rdy`, since TCB responses are fixed-delay and unstallable.

## Test plan
- **Single port:** IFN=2, DLY=1, only sub[0] reads adr 0x10 -> man.adr=0x10 the same cycle; the response `rdt` appears on sub[0] one cycle later; sub[1].rsp.rdt=0.
- **Full contention:** IFN=3, all vld=1 for 6 cycles with man.rdy=1 -> grant sequence 0,1,2,0,1,2. Each response returns to the matching port with DLY=1.
- **Stall lock:** sub[0] vld with man.rdy=0 for 3 cycles while sub[1] raises vld on cycle 1 -> gnt stays 0 for all 3 cycles. After rdy=1, the next grant is 1; sub[1].rdy=0 throughout the stall.
- **Pointer wrap and skip:** IFN=4, ptr=3 after a grant to port 2; vld on ports 0 and 1 -> grant 0, then 1.
- **Reset with responses in flight:** DLY=2, transfer on port 1, then rst low for one cycle at the next edge -> no `rsp` routed to any port; ptr=0 after release.
- **Zero delay:** DLY=0, alternating ports 0/1 write `wdt` 0xA5A5A5A5 / 0x5A5A5A5A -> `sts` routes combinationally to the granted port in the same cycle.
